// File: rtl/clock_display_mux.sv
// clock_display_mux: six-digit multiplexed 7-segment driver for HH.MM.SS.
// Captures the slow-domain time value safely, freezes it once per frame,
// converts each field to BCD and scans one digit per slot. Each slot opens
// with a short all-anodes-off gap to prevent ghosting between digits.
module clock_display_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 4,
  parameter int ACTIVE_LOW  = 1,
  parameter int LZ_BLANK    = 1
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  input  logic       dp_blink_en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic [2:0] digit_sel
);

  localparam int            PW        = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] LAST      = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD_END = PW'(GUARD);
  localparam logic          INV       = (ACTIVE_LOW != 0);
  localparam logic          LZ_ON     = (LZ_BLANK != 0);

  logic [16:0]   s1_reg, s2_reg, stable_reg, snapshot_reg;
  logic [PW-1:0] prescaler_reg;
  logic [2:0]    digit_sel_reg;
  logic [6:0]    seg_reg, seg_next;
  logic          dp_reg, dp_next;
  logic [5:0]    an_reg, an_next;

  logic          slot_end, frame_end;
  logic [5:0]    snap_sec, snap_min;
  logic [4:0]    snap_hr;
  logic [5:0]    field_val, field_max, bcd_digit;
  logic          lead_blank, in_guard;
  logic [6:0]    seg_hi;
  logic          dp_hi;
  logic [5:0]    an_hi;

  // Active-high segment pattern {g,f,e,d,c,b,a} for a decimal digit.
  function automatic logic [6:0] seg_code(input logic [5:0] d);
    case (d)
      6'd0:    seg_code = 7'h3F;
      6'd1:    seg_code = 7'h06;
      6'd2:    seg_code = 7'h5B;
      6'd3:    seg_code = 7'h4F;
      6'd4:    seg_code = 7'h66;
      6'd5:    seg_code = 7'h6D;
      6'd6:    seg_code = 7'h7D;
      6'd7:    seg_code = 7'h07;
      6'd8:    seg_code = 7'h7F;
      6'd9:    seg_code = 7'h6F;
      default: seg_code = 7'h00;
    endcase
  endfunction

  assign slot_end  = (prescaler_reg == LAST);
  assign frame_end = slot_end && (digit_sel_reg == 3'd5);

  // Two-stage capture; only a value seen identically on two edges is accepted.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      s1_reg     <= '0;
      s2_reg     <= '0;
      stable_reg <= '0;
    end else begin
      s1_reg <= {hours, minutes, seconds};
      s2_reg <= s1_reg;
      if (s1_reg == s2_reg) begin
        stable_reg <= s2_reg;
      end
    end
  end

  // Slot prescaler, digit scan index and once-per-frame snapshot.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      prescaler_reg <= '0;
      digit_sel_reg <= '0;
      snapshot_reg  <= '0;
    end else begin
      prescaler_reg <= slot_end ? '0 : prescaler_reg + PW'(1);
      if (slot_end) begin
        digit_sel_reg <= frame_end ? 3'd0 : digit_sel_reg + 3'd1;
      end
      if (frame_end) begin
        snapshot_reg <= stable_reg;
      end
    end
  end

  assign snap_sec = snapshot_reg[5:0];
  assign snap_min = snapshot_reg[11:6];
  assign snap_hr  = snapshot_reg[16:12];

  // Select the field for the current digit, convert to BCD and apply dash/blank rules.
  always_comb begin
    field_val = snap_sec;
    field_max = 6'd59;
    case (digit_sel_reg)
      3'd0, 3'd1: begin
        field_val = snap_sec;
        field_max = 6'd59;
      end
      3'd2, 3'd3: begin
        field_val = snap_min;
        field_max = 6'd59;
      end
      default: begin
        field_val = {1'b0, snap_hr};
        field_max = 6'd23;
      end
    endcase
    bcd_digit  = digit_sel_reg[0] ? (field_val / 6'd10) : (field_val % 6'd10);
    lead_blank = LZ_ON && (digit_sel_reg == 3'd5) && (snap_hr < 5'd10);
    if (field_val > field_max) begin
      seg_hi = 7'h40;
    end else if (lead_blank) begin
      seg_hi = 7'h00;
    end else begin
      seg_hi = seg_code(bcd_digit);
    end
    dp_hi = ((digit_sel_reg == 3'd2) || (digit_sel_reg == 3'd4)) &&
            (!dp_blink_en || !snap_sec[0]);
    in_guard = (prescaler_reg < GUARD_END);
    an_hi    = in_guard ? 6'd0 : (6'd1 << digit_sel_reg);
    seg_next = (in_guard ? 7'h00 : seg_hi) ^ {7{INV}};
    dp_next  = (in_guard ? 1'b0 : dp_hi) ^ INV;
    an_next  = an_hi ^ {6{INV}};
  end

  // Register the display drive so pins change cleanly once per clock.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      seg_reg <= {7{INV}};
      dp_reg  <= INV;
      an_reg  <= {6{INV}};
    end else begin
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
      an_reg  <= an_next;
    end
  end

  assign seg       = seg_reg;
  assign dp        = dp_reg;
  assign an        = an_reg;
  assign digit_sel = digit_sel_reg;

endmodule

// File: tb/tb_clock_display_mux.sv
// Bench for clock_display_mux: two instances (common-anode with leading-zero
// blanking, common-cathode without) share stimulus and are checked each cycle
// against a time-indexed model, plus hand-computed literal expectations.
module tb_clock_display_mux;

  localparam int RD    = 8;
  localparam int GD    = 2;
  localparam int FRAME = 6 * RD;

  logic       Clk;
  logic       reset;
  logic [5:0] seconds, minutes;
  logic [4:0] hours;
  logic       dp_blink_en;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;
  logic [5:0] an_a, an_b;
  logic [2:0] dsel_a, dsel_b;

  clock_display_mux #(.REFRESH_DIV(RD), .GUARD(GD), .ACTIVE_LOW(1), .LZ_BLANK(1)) dut_a (
    .Clk(Clk), .reset(reset), .seconds(seconds), .minutes(minutes), .hours(hours),
    .dp_blink_en(dp_blink_en), .seg(seg_a), .dp(dp_a), .an(an_a), .digit_sel(dsel_a)
  );

  clock_display_mux #(.REFRESH_DIV(RD), .GUARD(GD), .ACTIVE_LOW(0), .LZ_BLANK(0)) dut_b (
    .Clk(Clk), .reset(reset), .seconds(seconds), .minutes(minutes), .hours(hours),
    .dp_blink_en(dp_blink_en), .seg(seg_b), .dp(dp_b), .an(an_b), .digit_sel(dsel_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  logic [6:0] codes [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // What a digit must show, from the display rules alone.
  function automatic logic [6:0] seg_exp(input logic [16:0] snap, input int slot,
                                         input bit lz, input bit al);
    int sec, mn, hr, f, lim;
    logic [6:0] hi;
    sec = int'(snap[5:0]);
    mn  = int'(snap[11:6]);
    hr  = int'(snap[16:12]);
    if (slot < 2)      begin f = sec; lim = 59; end
    else if (slot < 4) begin f = mn;  lim = 59; end
    else               begin f = hr;  lim = 23; end
    if (f > lim) hi = 7'h40;
    else if (slot == 5 && lz && hr < 10) hi = 7'h00;
    else hi = codes[(slot % 2 == 1) ? f / 10 : f % 10];
    return al ? ~hi : hi;
  endfunction

  function automatic logic dp_exp(input logic [16:0] snap, input int slot,
                                  input bit blink, input bit al);
    logic on;
    on = (slot == 2 || slot == 4) && (!blink || snap[0] == 1'b0);
    return al ? ~on : on;
  endfunction

  function automatic logic [5:0] an_exp(input bit act, input int slot, input bit al);
    logic [5:0] hi;
    hi = act ? 6'(1 << slot) : 6'd0;
    return al ? ~hi : hi;
  endfunction

  // Model: time t counts clocks since reset; slot = (t/RD)%6, slot phase = t%RD.
  // A value is accepted once it has been sampled on two consecutive edges,
  // and copied for display on the last cycle of every frame.
  int          m_t, m_run, e_slot;
  logic [16:0] m_last, m_stab, m_snap, e_snap;
  logic        e_active, e_blink;
  logic [16:0] in_now;
  assign in_now = {hours, minutes, seconds};

  // Advance the model by one clock and record what the registered outputs must show.
  always @(posedge Clk or posedge reset) begin
    if (reset) begin
      m_t      <= 0;
      m_last   <= '0;
      m_run    <= 2;
      m_stab   <= '0;
      m_snap   <= '0;
      e_active <= 1'b0;
      e_slot   <= 0;
      e_snap   <= '0;
      e_blink  <= 1'b0;
    end else begin
      e_slot   <= (m_t / RD) % 6;
      e_active <= (m_t % RD) >= GD;
      e_snap   <= m_snap;
      e_blink  <= dp_blink_en;
      m_t      <= m_t + 1;
      if (m_run >= 2) m_stab <= m_last;
      if (in_now == m_last) m_run <= (m_run >= 2) ? 2 : m_run + 1;
      else begin
        m_last <= in_now;
        m_run  <= 1;
      end
      if (m_t % FRAME == FRAME - 1) m_snap <= m_stab;
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      check("digit_sel_a", 32'(dsel_a), 32'((m_t / RD) % 6));
      check("digit_sel_b", 32'(dsel_b), 32'((m_t / RD) % 6));
      check("an_a", 32'(an_a), 32'(an_exp(e_active, e_slot, 1'b1)));
      check("an_b", 32'(an_b), 32'(an_exp(e_active, e_slot, 1'b0)));
      if (reset) begin
        check("rst_seg_a", 32'(seg_a), 32'h7F);
        check("rst_dp_a", 32'(dp_a), 32'h1);
        check("rst_seg_b", 32'(seg_b), 32'h0);
        check("rst_dp_b", 32'(dp_b), 32'h0);
      end else if (e_active) begin
        check("seg_a", 32'(seg_a), 32'(seg_exp(e_snap, e_slot, 1'b1, 1'b1)));
        check("seg_b", 32'(seg_b), 32'(seg_exp(e_snap, e_slot, 1'b0, 1'b0)));
        check("dp_a", 32'(dp_a), 32'(dp_exp(e_snap, e_slot, e_blink, 1'b1)));
        check("dp_b", 32'(dp_b), 32'(dp_exp(e_snap, e_slot, e_blink, 1'b0)));
      end
    end
  end

  task automatic wait_boundary();
    int n;
    n = 0;
    while (dsel_b != 3'd5 && n < 200) begin @(negedge Clk); n++; end
    while (dsel_b != 3'd0 && n < 200) begin @(negedge Clk); n++; end
    if (n >= 200) begin
      n_total++;
      $display("FAIL wait_boundary: no frame wrap within %0d cycles, required < 200", n);
    end
  endtask

  task automatic wait_slot(input int k);
    int n;
    n = 0;
    while (an_b != 6'(1 << k) && n < 200) begin @(negedge Clk); n++; end
    if (n >= 200) begin
      n_total++;
      $display("FAIL wait_slot%0d: anode never active within %0d cycles, required < 200", k, n);
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hours   = 5'(h);
    minutes = 6'(m);
    seconds = 6'(s);
  endtask

  // Reset must blank everything at once; the first anode follows GD+1 edges after release.
  task automatic reset_pulse_check();
    reset = 1'b1;
    #1;
    check("rst_now_an_a", 32'(an_a), 32'h3F);
    check("rst_now_seg_a", 32'(seg_a), 32'h7F);
    check("rst_now_dp_a", 32'(dp_a), 32'h1);
    @(negedge Clk);
    reset = 1'b0;
    repeat (GD) begin
      @(posedge Clk);
      #1;
      check("post_rst_guard_an_a", 32'(an_a), 32'h3F);
    end
    @(posedge Clk);
    #1;
    check("first_anode_an_a", 32'(an_a), 32'h3E);
    check("first_anode_seg_a", 32'(seg_a), 32'h40);
  endtask

  logic [6:0] t2_seg [6] = '{7'h07, 7'h3F, 7'h6D, 7'h66, 7'h4F, 7'h06};
  logic       t2_dp  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    reset = 1'b1;
    dp_blink_en = 1'b0;
    set_time(0, 0, 0);
    repeat (3) @(negedge Clk);
    chk_en = 1'b1;
    reset_pulse_check();

    // 13:45:07 held for two frames, then every slot of a frame.
    set_time(13, 45, 7);
    wait_boundary();
    wait_boundary();
    @(negedge Clk); check("guard_cycle0_an_b", 32'(an_b), 32'h00);
    @(negedge Clk); check("guard_cycle1_an_b", 32'(an_b), 32'h00);
    @(negedge Clk); check("slot0_open_an_b", 32'(an_b), 32'h01);
    for (int k = 0; k < 6; k++) begin
      wait_slot(k);
      check($sformatf("hms_seg_slot%0d", k), 32'(seg_b), 32'(t2_seg[k]));
      check($sformatf("hms_dp_slot%0d", k), 32'(dp_b), 32'(t2_dp[k]));
    end

    // Leading-zero blanking on hours tens.
    set_time(5, 45, 7);
    wait_boundary();
    wait_boundary();
    wait_slot(4);
    check("lz_hours_units_b", 32'(seg_b), 32'h6D);
    wait_slot(5);
    check("lz_blank_seg_a", 32'(seg_a), 32'h7F);
    check("lz_blank_dp_a", 32'(dp_a), 32'h1);
    check("lz_off_seg_b", 32'(seg_b), 32'h3F);

    // Out-of-range seconds show dashes; minutes unaffected.
    set_time(13, 59, 60);
    wait_boundary();
    wait_boundary();
    for (int k = 0; k < 4; k++) begin
      wait_slot(k);
      check($sformatf("oor_seg_slot%0d", k), 32'(seg_b), (k < 2) ? 32'h40 : ((k == 2) ? 32'h6F : 32'h6D));
    end

    // Input change mid-frame with blinking separators.
    dp_blink_en = 1'b1;
    set_time(13, 45, 7);
    wait_boundary();
    wait_boundary();
    wait_slot(2);
    check("blink_odd_dp_b", 32'(dp_b), 32'h0);
    seconds = 6'd8;
    wait_slot(3);
    check("midframe_min_tens_b", 32'(seg_b), 32'h66);
    wait_slot(0);
    check("next_frame_sec_units_b", 32'(seg_b), 32'h7F);
    wait_slot(2);
    check("blink_even_dp_b", 32'(dp_b), 32'h1);

    // Unstable input for three frames, then settle.
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(posedge Clk);
      #2;
      seconds = (i % 2 == 0) ? 6'd30 : 6'd31;
    end
    seconds = 6'd21;
    wait_boundary();
    wait_boundary();
    wait_slot(0);
    check("settled_sec_units_b", 32'(seg_b), 32'h06);
    wait_slot(1);
    check("settled_sec_tens_b", 32'(seg_b), 32'h5B);

    // Reset in the middle of a slot.
    wait_slot(3);
    #2;
    reset_pulse_check();

    // Randomized phase: holds, per-cycle toggling, occasional resets.
    for (int it = 0; it < 80; it++) begin
      int mode;
      mode = $urandom_range(0, 9);
      dp_blink_en = 1'($urandom_range(0, 1));
      if (mode == 0) begin
        @(posedge Clk);
        #3;
        reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
      end else if (mode < 3) begin
        repeat ($urandom_range(2, 30)) begin
          @(posedge Clk);
          #2;
          set_time($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
        end
      end else begin
        if ($urandom_range(0, 4) == 0)
          set_time($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
        else
          set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
        repeat ($urandom_range(5, 120)) @(posedge Clk);
      end
    end

    @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
